// File: rtl/conv_frame_seq.sv
// rtl/conv_frame_seq.sv - row-serial frame sequencer around a 6x6 / 3x3 GF(2) convolution
module conv_frame_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       k_we,
    input  logic [8:0] k_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [1:0]  out_idx_q, out_idx_d;
    logic [35:0] img_q, img_d;
    logic [15:0] res_q, res_d;
    logic [8:0]  kern_q, kern_d;
    logic [15:0] conv_res;
    logic        in_hs;
    logic        out_hs;

    // Full 4x4 GF(2) convolution of the stored image with the stored kernel
    always_comb begin
        conv_res = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 3; k++) begin
                    for (int l = 0; l < 3; l++) begin
                        conv_res[i*4+j] = conv_res[i*4+j]
                                        ^ (img_q[(i+k)*6+j+l] & kern_q[k*3+l]);
                    end
                end
            end
        end
    end

    // Handshake-facing outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        out_valid = (state_q == ST_EMIT);
        busy      = (state_q != ST_IDLE);
        out_last  = (state_q == ST_EMIT) && (out_idx_q == 2'd3);
        out_data  = 4'h0;
        if (state_q == ST_EMIT) begin
            out_data = res_q[{out_idx_q, 2'b00} +: 4];
        end
        in_hs  = in_valid & in_ready;
        out_hs = out_valid & out_ready;
    end

    // Next-state logic: row collection, one-cycle evaluation, row emission
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        out_idx_d = out_idx_q;
        img_d     = img_q;
        res_d     = res_q;
        kern_d    = kern_q;
        case (state_q)
            ST_IDLE: begin
                // A kernel written alongside row 0 applies to this frame
                if (k_we) begin
                    kern_d = k_data;
                end
                if (in_hs) begin
                    img_d[5:0] = in_data;
                    row_cnt_d  = 3'd1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    for (int r = 1; r < 6; r++) begin
                        if (row_cnt_q == 3'(r)) begin
                            img_d[r*6 +: 6] = in_data;
                        end
                    end
                    if (row_cnt_q == 3'd5) begin
                        row_cnt_d = 3'd0;
                        state_d   = ST_CALC;
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
            end
            ST_CALC: begin
                res_d     = conv_res;
                out_idx_d = 2'd0;
                state_d   = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_hs) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort drops any beat in flight but keeps kernel, image and result
        if (clr) begin
            state_d   = ST_IDLE;
            row_cnt_d = 3'd0;
            out_idx_d = 2'd0;
            img_d     = img_q;
            res_d     = res_q;
            kern_d    = kern_q;
        end
    end

    // State and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= 3'd0;
            out_idx_q <= 2'd0;
            img_q     <= '0;
            res_q     <= '0;
            kern_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            out_idx_q <= out_idx_d;
            img_q     <= img_d;
            res_q     <= res_d;
            kern_q    <= kern_d;
        end
    end

endmodule
